axi_addr_remap: RTL and testbench
=================================

AXI_ADDR_REMAP -- requirements
Module: axi_addr_remap

Interface
REQ-001 Parameter NoRules, default 4: number of remap rules; SHALL be at least 1.
REQ-002 Parameter SlvAddrWidth, default 64: slave-side address width.
REQ-003 Parameter MstAddrWidth, default SlvAddrWidth: master-side address width.
REQ-004 Parameter rule_t, default logic: the package rule type {valid, base, mask, offset}; base and mask are SlvAddrWidth bits; offset is MstAddrWidth bits.
REQ-005 Port clk_i, input, 1 bit: the single clock; the block SHALL use one clock only and all state SHALL change on its rising edge.
REQ-006 Port rst_i, input, 1 bit: reset; the block SHALL use a synchronous, active-high reset.
REQ-007 Port cfg_we_i, input, 1 bit: rule-table write strobe.
REQ-008 Port cfg_idx_i, input, $clog2(NoRules) bits: rule index to write.
REQ-009 Port cfg_rule_i, input, rule_t: rule data to write.
REQ-010 Port aw_addr_i / ar_addr_i, input, SlvAddrWidth bits: slave-side AW and AR addresses.
REQ-011 Port aw_valid_i, aw_ready_i / ar_valid_i, ar_ready_i, input, 1 bit each: observed downstream handshake per channel.
REQ-012 Port mst_aw_addr_o / mst_ar_addr_o, output, MstAddrWidth bits: translated addresses fed to the address-modify stage.
REQ-013 Port aw_miss_o / ar_miss_o, output, 1 bit each: no rule matched the presented address.

Function
REQ-014 The match condition for rule i SHALL be rule[i].valid && ((addr & rule[i].mask) == rule[i].base); when several rules match, the lowest index SHALL win.
REQ-015 On a hit, the translated address SHALL be rule.offset | zero-extend/truncate(addr & ~rule.mask) to MstAddrWidth; the miss flag SHALL be 0.
REQ-016 On a miss, the translated address SHALL be addr zero-extended or truncated to MstAddrWidth; the miss flag SHALL be 1.
REQ-017 The AW and AR channels SHALL each have an independent FSM with two states, IDLE and HOLD.
REQ-018 In IDLE, the outputs SHALL be the combinational translation of the current address against the current table (zero latency).
REQ-019 In IDLE, when valid && !ready, the FSM SHALL capture the translated address and miss flag into registers and go to HOLD.
REQ-020 In IDLE, when valid && ready, the FSM SHALL stay in IDLE (single-cycle handshake).
REQ-021 In HOLD, the outputs SHALL be the registered values, stable regardless of input address changes or table writes.
REQ-022 In HOLD, valid && ready SHALL return the FSM to IDLE in the next cycle.
REQ-023 In HOLD, a drop of valid (protocol violation) SHALL return the FSM to IDLE without asserting anything.
REQ-024 A table write SHALL take effect in the cycle after cfg_we_i; a lookup in the write cycle SHALL use the old entry.
REQ-025 Simultaneous AW and AR lookups SHALL both complete in the same cycle, and both SHALL be allowed to coincide with a table write.

Reset
REQ-026 While rst_i is high, both FSMs SHALL be IDLE, holding registers 0, and all table entries invalid; outputs SHALL therefore pass the address through with miss = 1.
REQ-027 Reset asserted mid-HOLD SHALL abandon the captured value; the first cycle after reset SHALL be IDLE.

Configuration
REQ-028 With AXI_ADDR_REMAP_MISS_CNT_EN defined, the block SHALL provide outputs aw_miss_cnt_o and ar_miss_cnt_o, 32 bits each.
REQ-029 Each counter SHALL increment once per completed handshake (valid && ready) with miss = 1, SHALL saturate at 32'hFFFF_FFFF, and SHALL reset to 0.
REQ-030 Without the macro, the counter ports and logic SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-031 Package axi_addr_remap_pkg SHALL hold the rule_t typedef template and the default NoRules constant.
REQ-032 Sub-module axi_addr_remap_lookup (pure combinational match, priority and translate) SHALL be instantiated once per channel; FSM, table and counters SHALL live in the top module.

Verification
REQ-033 Rule 0 {valid, base 0x8000_0000, mask 0xF000_0000, offset 0x1_0000_0000}; AW addr 0x8000_1234 with valid and ready high -> same-cycle mst_aw_addr_o 0x1_0000_1234, aw_miss_o 0.
REQ-034 AW valid held with ready low for 5 cycles while aw_addr_i toggles and rule 0 is rewritten -> output frozen at the first-cycle value until the ready cycle, then IDLE.
REQ-035 Rules 0 and 1 both matching 0x8000_0000 -> the rule 0 translation is used.
REQ-036 AR addr 0x4000_0000 with no matching rule -> mst_ar_addr_o 0x4000_0000, ar_miss_o 1; with the macro defined, ar_miss_cnt_o goes 0 -> 1 after the handshake.
REQ-037 rst_i pulsed during AW HOLD -> next cycle in IDLE with passthrough and all rules invalid.
REQ-038 Counter preset to 0xFFFF_FFFE followed by 3 missed handshakes -> counter reads 0xFFFF_FFFF.

Source files
------------

// File: rtl/axi_addr_remap_pkg.sv
// Shared types and defaults for the AXI address remapper.
// The rule_t template below is sized for the default 64-bit address widths.
package axi_addr_remap_pkg;

    localparam int unsigned DefaultNoRules   = 4;
    localparam int unsigned DefaultAddrWidth = 64;

    typedef struct packed {
        logic                        valid;
        logic [DefaultAddrWidth-1:0] base;
        logic [DefaultAddrWidth-1:0] mask;
        logic [DefaultAddrWidth-1:0] offset;
    } rule_t;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StHold = 1'b1;

endpackage

// File: rtl/axi_addr_remap_lookup.sv
// Combinational rule match, lowest-index priority and address translation.
module axi_addr_remap_lookup
    import axi_addr_remap_pkg::*;
#(
    parameter int unsigned NoRules      = DefaultNoRules,
    parameter int unsigned SlvAddrWidth = 64,
    parameter int unsigned MstAddrWidth = SlvAddrWidth,
    parameter type         rule_t       = axi_addr_remap_pkg::rule_t
) (
    input  logic [SlvAddrWidth-1:0] addr_i,
    input  rule_t [NoRules-1:0]     rules_i,
    output logic [MstAddrWidth-1:0] addr_o,
    output logic                    miss_o
);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        addr_o = MstAddrWidth'(addr_i);
        miss_o = 1'b1;
        // Walk from the highest index down so the lowest matching rule is the last to assign.
        for (int i = int'(NoRules) - 1; i >= 0; i--) begin
            if (rules_i[i].valid && ((addr_i & rules_i[i].mask) == rules_i[i].base)) begin
                addr_o = rules_i[i].offset | MstAddrWidth'(addr_i & ~rules_i[i].mask);
                miss_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_addr_remap.sv
// AXI AW/AR address remapper: rule table plus a per-channel IDLE/HOLD stability FSM.
// Define AXI_ADDR_REMAP_MISS_CNT_EN to add saturating per-channel miss counters.
module axi_addr_remap
    import axi_addr_remap_pkg::*;
#(
    parameter int unsigned NoRules      = DefaultNoRules,
    parameter int unsigned SlvAddrWidth = 64,
    parameter int unsigned MstAddrWidth = SlvAddrWidth,
    parameter type         rule_t       = axi_addr_remap_pkg::rule_t
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic                                            cfg_we_i,
    input  logic [(NoRules > 1 ? $clog2(NoRules) : 1)-1:0]  cfg_idx_i,
    input  rule_t                                           cfg_rule_i,
    input  logic [SlvAddrWidth-1:0]                         aw_addr_i,
    input  logic                                            aw_valid_i,
    input  logic                                            aw_ready_i,
    input  logic [SlvAddrWidth-1:0]                         ar_addr_i,
    input  logic                                            ar_valid_i,
    input  logic                                            ar_ready_i,
    output logic [MstAddrWidth-1:0]                         mst_aw_addr_o,
    output logic [MstAddrWidth-1:0]                         mst_ar_addr_o,
    output logic                                            aw_miss_o,
`ifdef AXI_ADDR_REMAP_MISS_CNT_EN
    output logic [31:0]                                     aw_miss_cnt_o,
    output logic [31:0]                                     ar_miss_cnt_o,
`endif
    output logic                                            ar_miss_o
);

    rule_t [NoRules-1:0] table_q, table_d;

    always_comb begin
        table_d = table_q;
        if (cfg_we_i && (32'(cfg_idx_i) < NoRules)) begin
            table_d[cfg_idx_i] = cfg_rule_i;
        end
    end

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        // NOTE: the table is a small flop array, so it is cleared on reset to start with every rule invalid.
        if (rst_i) begin
            table_q <= '0;
        end else begin
            table_q <= table_d;
        end
    end

    // Channel 0 is AW, channel 1 is AR.
    logic [SlvAddrWidth-1:0] slv_addr [2];
    logic [MstAddrWidth-1:0] mst_addr [2];
    logic [1:0]              chan_valid, chan_ready, chan_miss;

    assign slv_addr[0] = aw_addr_i;
    assign slv_addr[1] = ar_addr_i;
    assign chan_valid  = {ar_valid_i, aw_valid_i};
    assign chan_ready  = {ar_ready_i, aw_ready_i};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [MstAddrWidth-1:0] lut_addr, hold_addr_q, hold_addr_d, out_addr;
        logic                    lut_miss, hold_miss_q, hold_miss_d, out_miss;
        logic [0:0]              state_q, state_d;

        axi_addr_remap_lookup #(
            .NoRules      (NoRules),
            .SlvAddrWidth (SlvAddrWidth),
            .MstAddrWidth (MstAddrWidth),
            .rule_t       (rule_t)
        ) i_lookup (
            .addr_i  (slv_addr[ch]),
            .rules_i (table_q),
            .addr_o  (lut_addr),
            .miss_o  (lut_miss)
        );

        always_comb begin
            state_d     = state_q;
            hold_addr_d = hold_addr_q;
            hold_miss_d = hold_miss_q;
            case (state_q)
                StIdle: begin
                    if (chan_valid[ch] && !chan_ready[ch]) begin
                        state_d     = StHold;
                        hold_addr_d = lut_addr;
                        hold_miss_d = lut_miss;
                    end
                end
                default: begin
                    // A dropped valid is a protocol violation; just release the hold.
                    if (!chan_valid[ch] || chan_ready[ch]) begin
                        state_d = StIdle;
                    end
                end
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q     <= StIdle;
                hold_addr_q <= '0;
                hold_miss_q <= 1'b0;
            end else begin
                state_q     <= state_d;
                hold_addr_q <= hold_addr_d;
                hold_miss_q <= hold_miss_d;
            end
        end

        // While reset is high the table reads as empty, so present a plain passthrough miss.
        always_comb begin
            if (rst_i) begin
                out_addr = MstAddrWidth'(slv_addr[ch]);
                out_miss = 1'b1;
            end else if (state_q == StHold) begin
                out_addr = hold_addr_q;
                out_miss = hold_miss_q;
            end else begin
                out_addr = lut_addr;
                out_miss = lut_miss;
            end
        end

        assign mst_addr[ch]  = out_addr;
        assign chan_miss[ch] = out_miss;

`ifdef AXI_ADDR_REMAP_MISS_CNT_EN
        logic [31:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (chan_valid[ch] && chan_ready[ch] && out_miss && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
`endif
    end

    assign mst_aw_addr_o = mst_addr[0];
    assign mst_ar_addr_o = mst_addr[1];
    assign aw_miss_o     = chan_miss[0];
    assign ar_miss_o     = chan_miss[1];

`ifdef AXI_ADDR_REMAP_MISS_CNT_EN
    assign aw_miss_cnt_o = g_chan[0].cnt_q;
    assign ar_miss_cnt_o = g_chan[1].cnt_q;
`endif

endmodule

// File: tb/tb_axi_addr_remap.sv
// Scoreboard bench for axi_addr_remap: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_axi_addr_remap;
    import axi_addr_remap_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_idx_i;
    rule_t       cfg_rule_i;
    logic [63:0] aw_addr_i, ar_addr_i;
    logic        aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i;
    logic [63:0] mst_aw_addr_o, mst_ar_addr_o;
    logic        aw_miss_o, ar_miss_o;
`ifdef AXI_ADDR_REMAP_MISS_CNT_EN
    logic [31:0] aw_miss_cnt_o, ar_miss_cnt_o;
`endif

    axi_addr_remap #(
        .NoRules      (4),
        .SlvAddrWidth (64),
        .MstAddrWidth (64)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_idx_i     (cfg_idx_i),
        .cfg_rule_i    (cfg_rule_i),
        .aw_addr_i     (aw_addr_i),
        .aw_valid_i    (aw_valid_i),
        .aw_ready_i    (aw_ready_i),
        .ar_addr_i     (ar_addr_i),
        .ar_valid_i    (ar_valid_i),
        .ar_ready_i    (ar_ready_i),
        .mst_aw_addr_o (mst_aw_addr_o),
        .mst_ar_addr_o (mst_ar_addr_o),
        .aw_miss_o     (aw_miss_o),
`ifdef AXI_ADDR_REMAP_MISS_CNT_EN
        .aw_miss_cnt_o (aw_miss_cnt_o),
        .ar_miss_cnt_o (ar_miss_cnt_o),
`endif
        .ar_miss_o     (ar_miss_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard: channel 0 = AW, 1 = AR, 2 = AR miss counter, 3 = AW miss counter.
    int          q_cyc  [$];
    int          q_ch   [$];
    logic [63:0] q_addr [$];
    logic        q_miss [$];
    string       q_name [$];

    int          m_cyc, m_ch;
    logic [63:0] m_addr;
    logic        m_miss;
    string       m_name;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic expect_out(input int ch, input logic [63:0] a, input logic m, input string nm);
        q_cyc.push_back(cyc);
        q_ch.push_back(ch);
        q_addr.push_back(a);
        q_miss.push_back(m);
        q_name.push_back(nm);
    endtask

    always @(negedge clk_i) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            m_cyc  = q_cyc.pop_front();
            m_ch   = q_ch.pop_front();
            m_addr = q_addr.pop_front();
            m_miss = q_miss.pop_front();
            m_name = q_name.pop_front();
            if (m_cyc != cyc) begin
                check({m_name, "_stale"}, 64'(m_cyc), 64'(cyc));
            end else if (m_ch == 0) begin
                check({m_name, "_addr"}, mst_aw_addr_o, m_addr);
                check({m_name, "_miss"}, 64'(aw_miss_o), 64'(m_miss));
            end else if (m_ch == 1) begin
                check({m_name, "_addr"}, mst_ar_addr_o, m_addr);
                check({m_name, "_miss"}, 64'(ar_miss_o), 64'(m_miss));
`ifdef AXI_ADDR_REMAP_MISS_CNT_EN
            end else if (m_ch == 2) begin
                check(m_name, 64'(ar_miss_cnt_o), m_addr);
            end else begin
                check(m_name, 64'(aw_miss_cnt_o), m_addr);
`endif
            end
        end
    end

    function automatic rule_t mk_rule(input logic v, input logic [63:0] b, input logic [63:0] m,
                                      input logic [63:0] o);
        rule_t r;
        r.valid  = v;
        r.base   = b;
        r.mask   = m;
        r.offset = o;
        return r;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_rule(input logic [1:0] idx, input rule_t r);
        cfg_we_i   = 1'b1;
        cfg_idx_i  = idx;
        cfg_rule_i = r;
    endtask

    logic [63:0] toggle_addr [4];
    rule_t       rule0, rule0_moved;

    initial begin
        toggle_addr[0] = 64'h4000_0000;
        toggle_addr[1] = 64'h8000_1111;
        toggle_addr[2] = 64'h0000_1ABC;
        toggle_addr[3] = 64'h8000_2222;
        rule0       = mk_rule(1'b1, 64'h8000_0000, 64'hF000_0000, 64'h1_0000_0000);
        rule0_moved = mk_rule(1'b1, 64'h8000_0000, 64'hF000_0000, 64'h5_0000_0000);

        rst_i      = 1'b1;
        cfg_we_i   = 1'b0;
        cfg_idx_i  = '0;
        cfg_rule_i = '0;
        aw_addr_i  = 64'h1234_5678;
        ar_addr_i  = 64'h0000_1ABC;
        aw_valid_i = 1'b0;
        aw_ready_i = 1'b0;
        ar_valid_i = 1'b0;
        ar_ready_i = 1'b0;

        // Reset: passthrough with miss on both channels.
        step();
        expect_out(0, 64'h1234_5678, 1'b1, "rst_aw_pass");
        expect_out(1, 64'h0000_1ABC, 1'b1, "rst_ar_pass");
        step();
`ifdef AXI_ADDR_REMAP_MISS_CNT_EN
        expect_out(2, 64'h0, 1'b0, "rst_ar_cnt");
        expect_out(3, 64'h0, 1'b0, "rst_aw_cnt");
`endif

        // Write rule 0; lookup in the write cycle still sees the empty table.
        rst_i      = 1'b0;
        write_rule(2'd0, rule0);
        aw_addr_i  = 64'h8000_1234;
        aw_valid_i = 1'b1;
        aw_ready_i = 1'b1;
        expect_out(0, 64'h8000_1234, 1'b1, "wr_cycle_old");
        step();
        cfg_we_i = 1'b0;
        expect_out(0, 64'h1_0000_1234, 1'b0, "rule0_hit");
        step();

        // Rules 1 and 2.
        aw_valid_i = 1'b0;
        aw_ready_i = 1'b0;
        write_rule(2'd1, mk_rule(1'b1, 64'h8000_0000, 64'hFFFF_0000, 64'h2_0000_0000));
        step();
        write_rule(2'd2, mk_rule(1'b1, 64'h0000_1000, 64'hFFFF_F000, 64'h3_0000_0000));
        step();
        cfg_we_i = 1'b0;

        // Overlapping rules 0 and 1: rule 0 wins. AR hits rule 2 in the same cycle.
        aw_addr_i  = 64'h8000_0000;
        aw_valid_i = 1'b1;
        aw_ready_i = 1'b1;
        ar_addr_i  = 64'h0000_1ABC;
        ar_valid_i = 1'b1;
        ar_ready_i = 1'b1;
        expect_out(0, 64'h1_0000_0000, 1'b0, "prio_rule0");
        expect_out(1, 64'h3_0000_0ABC, 1'b0, "rule2_hit");
`ifdef AXI_ADDR_REMAP_MISS_CNT_EN
        expect_out(3, 64'h1, 1'b0, "aw_cnt_one");
`endif
        step();

        // AR miss handshake alongside an AW hit.
        ar_addr_i = 64'h4000_0000;
        aw_addr_i = 64'h8000_00FF;
        expect_out(1, 64'h4000_0000, 1'b1, "ar_miss");
        expect_out(0, 64'h1_0000_00FF, 1'b0, "aw_hit_with_ar_miss");
`ifdef AXI_ADDR_REMAP_MISS_CNT_EN
        expect_out(2, 64'h0, 1'b0, "ar_cnt_before");
`endif
        step();

        // Invalidate rule 0 while looking up: old entry still used this cycle.
        ar_valid_i = 1'b0;
        ar_ready_i = 1'b0;
        write_rule(2'd0, mk_rule(1'b0, 64'h8000_0000, 64'hF000_0000, 64'h1_0000_0000));
        expect_out(0, 64'h1_0000_00FF, 1'b0, "invalidate_old");
`ifdef AXI_ADDR_REMAP_MISS_CNT_EN
        expect_out(2, 64'h1, 1'b0, "ar_cnt_after");
`endif
        step();
        cfg_we_i = 1'b0;
        expect_out(0, 64'h2_0000_00FF, 1'b0, "rule1_fallback");
        step();
        aw_valid_i = 1'b0;
        aw_ready_i = 1'b0;
        write_rule(2'd0, rule0);
        step();
        cfg_we_i = 1'b0;

        // HOLD: ready low for 5 cycles, address toggling, rule 0 rewritten.
        aw_addr_i  = 64'h8000_0ABC;
        aw_valid_i = 1'b1;
        aw_ready_i = 1'b0;
        ar_addr_i  = 64'h0000_1ABC;
        ar_valid_i = 1'b1;
        ar_ready_i = 1'b1;
        expect_out(0, 64'h1_0000_0ABC, 1'b0, "hold_first");
        expect_out(1, 64'h3_0000_0ABC, 1'b0, "ar_indep");
        step();
        ar_valid_i = 1'b0;
        ar_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            aw_addr_i = toggle_addr[i];
            if (i == 0) write_rule(2'd0, rule0_moved);
            else cfg_we_i = 1'b0;
            expect_out(0, 64'h1_0000_0ABC, 1'b0, "hold_frozen");
            step();
        end
        aw_addr_i  = 64'h9999_0000;
        aw_ready_i = 1'b1;
        expect_out(0, 64'h1_0000_0ABC, 1'b0, "hold_ready");
        step();
        aw_valid_i = 1'b0;
        aw_ready_i = 1'b0;
        aw_addr_i  = 64'h8000_0ABC;
        expect_out(0, 64'h5_0000_0ABC, 1'b0, "hold_release_idle");
        step();

        // Valid dropped during HOLD.
        aw_addr_i  = 64'h8000_0001;
        aw_valid_i = 1'b1;
        expect_out(0, 64'h5_0000_0001, 1'b0, "drop_capture");
        step();
        aw_valid_i = 1'b0;
        aw_addr_i  = 64'h4000_0000;
        expect_out(0, 64'h5_0000_0001, 1'b0, "drop_held");
        step();
        expect_out(0, 64'h4000_0000, 1'b1, "drop_idle");
        step();

        // Reset pulsed during HOLD.
        aw_addr_i  = 64'h8000_0002;
        aw_valid_i = 1'b1;
        expect_out(0, 64'h5_0000_0002, 1'b0, "pre_rst_capture");
        step();
        rst_i     = 1'b1;
        aw_addr_i = 64'h8000_0003;
        expect_out(0, 64'h8000_0003, 1'b1, "rst_in_hold");
        expect_out(1, 64'h0000_1ABC, 1'b1, "rst_in_hold_ar");
        step();
        rst_i = 1'b0;
        expect_out(0, 64'h8000_0003, 1'b1, "post_rst_idle");
        expect_out(1, 64'h0000_1ABC, 1'b1, "post_rst_rules_invalid");
        step();
        aw_addr_i  = 64'h7000_0000;
        aw_ready_i = 1'b1;
        expect_out(0, 64'h8000_0003, 1'b1, "post_rst_captured");
        step();
        aw_valid_i = 1'b0;
        aw_ready_i = 1'b0;
        expect_out(0, 64'h7000_0000, 1'b1, "post_rst_release");
`ifdef AXI_ADDR_REMAP_MISS_CNT_EN
        expect_out(2, 64'h0, 1'b0, "ar_cnt_post_rst");
`endif
        step();

`ifdef AXI_ADDR_REMAP_MISS_CNT_EN
        // Saturation: preset near the top, then three missed AR handshakes.
        dut.g_chan[1].cnt_q = 32'hFFFF_FFFE;
        ar_addr_i  = 64'h4000_0000;
        ar_valid_i = 1'b1;
        ar_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        ar_valid_i = 1'b0;
        ar_ready_i = 1'b0;
        expect_out(2, 64'hFFFF_FFFF, 1'b0, "ar_cnt_saturate");
        step();
`endif

        step();
        step();
        n_cmp++;
        if (q_cyc.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_cyc.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
